// File: rtl/aes_uart_pkg.sv
// aes_uart_pkg: shared definitions for the UART-to-AES command controller.
//   - state_t     : controller FSM states
//   - CMD_*_DFLT  : default command bytes (key load, encrypt, core reset)
//   - ACK_/RSP_*  : response bytes returned to the host
//   - BLOCK_BYTES : bytes per 128-bit block, LAST_BYTE is its final index
//   - accepts_rx(): states in which an incoming byte is consumed
package aes_uart_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_RX_KEY   = 4'd1,
    ST_RX_DAT   = 4'd2,
    ST_KEY_GO   = 4'd3,
    ST_KEY_WAIT = 4'd4,
    ST_ENC_GO   = 4'd5,
    ST_ENC_WAIT = 4'd6,
    ST_TX_RES   = 4'd7,
    ST_TX_ACK   = 4'd8,
    ST_RST_HOLD = 4'd9
  } state_t;

  localparam logic [7:0] CMD_KEY_DFLT = 8'h4B;  // 'K'
  localparam logic [7:0] CMD_ENC_DFLT = 8'h44;  // 'D'
  localparam logic [7:0] CMD_RST_DFLT = 8'h52;  // 'R'

  localparam logic [7:0] ACK_KEY = 8'h6B;
  localparam logic [7:0] ACK_RST = 8'h72;
  localparam logic [7:0] RSP_UNK = 8'h3F;
  localparam logic [7:0] RSP_TMO = 8'hEE;

  localparam int unsigned BLOCK_BYTES = 16;
  localparam logic [3:0]  LAST_BYTE   = 4'(BLOCK_BYTES - 1);

  // Only the idle and block-assembly states consume RX bytes; anywhere else
  // an incoming byte is an overrun.
  function automatic logic accepts_rx(input state_t st);
    return (st == ST_IDLE) || (st == ST_RX_KEY) || (st == ST_RX_DAT);
  endfunction

endpackage

// File: rtl/aes_byte_shifter.sv
// aes_byte_shifter: 128-bit register that moves a byte at a time.
//   clk, rst_n : clock, asynchronous active-low reset
//   shift_en   : shift left by one byte, byte_in enters at the low end
//   byte_in    : byte shifted in (tie to zero when unloading)
//   load_en    : parallel load of load_data, clears the byte counter
//   load_data  : 128-bit parallel load value
//   data       : current register contents (bits [127:120] are the head byte)
//   cnt        : number of shifts since reset/load, modulo 16
module aes_byte_shifter (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         shift_en,
  input  logic [7:0]   byte_in,
  input  logic         load_en,
  input  logic [127:0] load_data,
  output logic [127:0] data,
  output logic [3:0]   cnt
);

  logic [127:0] data_r;
  logic [3:0]   cnt_r;

  // Shift/load register with its byte counter; load takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r <= 128'h0;
      cnt_r  <= 4'h0;
    end else if (load_en) begin
      data_r <= load_data;
      cnt_r  <= 4'h0;
    end else if (shift_en) begin
      data_r <= {data_r[119:0], byte_in};
      cnt_r  <= cnt_r + 4'h1;
    end else begin
      data_r <= data_r;
      cnt_r  <= cnt_r;
    end
  end

  assign data = data_r;
  assign cnt  = cnt_r;

endmodule

// File: rtl/aes_uart_cmd_ctrl.sv
// aes_uart_cmd_ctrl: byte-level command controller between a UART byte
// receiver/transmitter and the AES core.
//   CLK, NRST        : clock, asynchronous active-low reset
//   RX_DATA, RX_VLD  : received byte and its one-cycle strobe
//   TX_DATA, TX_VLD  : byte to transmit, held until TX_RDY
//   TX_RDY           : transmitter accepts when TX_VLD & TX_RDY
//   KIN_AES, DIN_AES : assembled key / plaintext, first byte at [127:120]
//   KDRDY_AES        : one-cycle key-ready pulse
//   EN_AES           : one-cycle encrypt-start pulse
//   RSTn_AES         : core reset, active low
//   BUSY_AES, KVLD_AES, DVLD_AES, DOUT_AES : core status and ciphertext
//   OVR              : sticky flag, an RX byte arrived while busy and was dropped
// TIMEOUT is compared against a 16-bit counter, so it must not exceed 65535.
module aes_uart_cmd_ctrl
  import aes_uart_pkg::*;
#(
  parameter int unsigned RST_CYCLES = 16,
  parameter int unsigned TIMEOUT    = 65535,
  parameter logic [7:0]  CMD_KEY    = CMD_KEY_DFLT,
  parameter logic [7:0]  CMD_ENC    = CMD_ENC_DFLT,
  parameter logic [7:0]  CMD_RST    = CMD_RST_DFLT
) (
  input  logic         CLK,
  input  logic         NRST,
  input  logic [7:0]   RX_DATA,
  input  logic         RX_VLD,
  output logic [7:0]   TX_DATA,
  output logic         TX_VLD,
  input  logic         TX_RDY,
  output logic [127:0] KIN_AES,
  output logic [127:0] DIN_AES,
  output logic         KDRDY_AES,
  output logic         EN_AES,
  output logic         RSTn_AES,
  input  logic         BUSY_AES,
  input  logic         KVLD_AES,
  input  logic         DVLD_AES,
  input  logic [127:0] DOUT_AES,
  output logic         OVR
);

  state_t       state_r, state_nxt_s;
  logic [15:0]  wait_cnt_r;
  logic         tmo_hit_s;
  logic         rst_done_s;

  logic         rx_shift_s, rx_last_s;
  logic [127:0] rx_data_s;
  logic [3:0]   rx_cnt_s;

  logic         tx_acc_s, tx_load_s;
  logic [127:0] tx_load_data_s;
  logic [127:0] tx_data_s;
  logic [3:0]   tx_cnt_s;

  logic         ack_set_s;
  logic [7:0]   ack_byte_s;
  logic         key_load_s, dat_load_s, tx_cap_s, en_s;

  // Head byte of the RX register is never needed (the 16th byte pushes it
  // out) and the TX body is only ever read through its head byte.
  logic         unused_s;
  assign unused_s = ^{rx_data_s[127:120], tx_data_s[119:0]};

  assign rx_shift_s = RX_VLD && ((state_r == ST_RX_KEY) || (state_r == ST_RX_DAT));
  assign rx_last_s  = rx_shift_s && (rx_cnt_s == LAST_BYTE);
  assign tx_acc_s   = (state_r == ST_TX_RES) && TX_VLD && TX_RDY;
  assign tmo_hit_s  = (wait_cnt_r == 16'(TIMEOUT));
  assign rst_done_s = (wait_cnt_r == 16'(RST_CYCLES - 1));

  // Ciphertext and single-byte responses share the TX register; a response
  // is loaded into the head byte so TX_DATA always comes from one place.
  assign tx_load_s      = tx_cap_s || ack_set_s;
  assign tx_load_data_s = tx_cap_s ? DOUT_AES : {ack_byte_s, 120'h0};
  assign TX_DATA        = tx_data_s[127:120];

  aes_byte_shifter u_rx_shifter (
    .clk       (CLK),
    .rst_n     (NRST),
    .shift_en  (rx_shift_s),
    .byte_in   (RX_DATA),
    .load_en   (1'b0),
    .load_data (128'h0),
    .data      (rx_data_s),
    .cnt       (rx_cnt_s)
  );

  aes_byte_shifter u_tx_shifter (
    .clk       (CLK),
    .rst_n     (NRST),
    .shift_en  (tx_acc_s),
    .byte_in   (8'h00),
    .load_en   (tx_load_s),
    .load_data (tx_load_data_s),
    .data      (tx_data_s),
    .cnt       (tx_cnt_s)
  );

  // FSM state register.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode plus the one-cycle action strobes of each transition.
  always_comb begin
    state_nxt_s = state_r;
    ack_set_s   = 1'b0;
    ack_byte_s  = 8'h00;
    key_load_s  = 1'b0;
    dat_load_s  = 1'b0;
    tx_cap_s    = 1'b0;
    en_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (RX_VLD) begin
          if (RX_DATA == CMD_KEY) begin
            state_nxt_s = ST_RX_KEY;
          end else if (RX_DATA == CMD_ENC) begin
            state_nxt_s = ST_RX_DAT;
          end else if (RX_DATA == CMD_RST) begin
            state_nxt_s = ST_RST_HOLD;
          end else begin
            state_nxt_s = ST_TX_ACK;
            ack_set_s   = 1'b1;
            ack_byte_s  = RSP_UNK;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RX_KEY: begin
        if (rx_last_s) begin
          state_nxt_s = ST_KEY_GO;
          key_load_s  = 1'b1;
        end else begin
          state_nxt_s = ST_RX_KEY;
        end
      end
      ST_RX_DAT: begin
        if (rx_last_s) begin
          state_nxt_s = ST_ENC_GO;
          dat_load_s  = 1'b1;
        end else begin
          state_nxt_s = ST_RX_DAT;
        end
      end
      ST_KEY_GO: begin
        state_nxt_s = ST_KEY_WAIT;
      end
      ST_KEY_WAIT: begin
        // The strobe is tested first so a completion on the timeout cycle wins.
        if (KVLD_AES) begin
          state_nxt_s = ST_TX_ACK;
          ack_set_s   = 1'b1;
          ack_byte_s  = ACK_KEY;
        end else if (tmo_hit_s) begin
          state_nxt_s = ST_TX_ACK;
          ack_set_s   = 1'b1;
          ack_byte_s  = RSP_TMO;
        end else begin
          state_nxt_s = ST_KEY_WAIT;
        end
      end
      ST_ENC_GO: begin
        // A core that never drops BUSY is bounded by the same timeout.
        if (!BUSY_AES) begin
          state_nxt_s = ST_ENC_WAIT;
          en_s        = 1'b1;
        end else if (tmo_hit_s) begin
          state_nxt_s = ST_TX_ACK;
          ack_set_s   = 1'b1;
          ack_byte_s  = RSP_TMO;
        end else begin
          state_nxt_s = ST_ENC_GO;
        end
      end
      ST_ENC_WAIT: begin
        if (DVLD_AES) begin
          state_nxt_s = ST_TX_RES;
          tx_cap_s    = 1'b1;
        end else if (tmo_hit_s) begin
          state_nxt_s = ST_TX_ACK;
          ack_set_s   = 1'b1;
          ack_byte_s  = RSP_TMO;
        end else begin
          state_nxt_s = ST_ENC_WAIT;
        end
      end
      ST_TX_RES: begin
        if (tx_acc_s && (tx_cnt_s == LAST_BYTE)) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_TX_RES;
        end
      end
      ST_TX_ACK: begin
        if (TX_RDY) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_TX_ACK;
        end
      end
      ST_RST_HOLD: begin
        if (rst_done_s) begin
          state_nxt_s = ST_TX_ACK;
          ack_set_s   = 1'b1;
          ack_byte_s  = ACK_RST;
        end else begin
          state_nxt_s = ST_RST_HOLD;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Shared wait counter: restarts on entry to KEY_WAIT, ENC_GO or RST_HOLD;
  // ENC_GO -> ENC_WAIT keeps counting so BUSY stall time is included.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      wait_cnt_r <= 16'h0;
    end else if ((state_nxt_s != state_r) &&
                 ((state_nxt_s == ST_KEY_WAIT) || (state_nxt_s == ST_ENC_GO) ||
                  (state_nxt_s == ST_RST_HOLD))) begin
      wait_cnt_r <= 16'h0;
    end else if (((state_r == ST_KEY_WAIT) || (state_r == ST_ENC_GO) ||
                  (state_r == ST_ENC_WAIT) || (state_r == ST_RST_HOLD)) &&
                 (wait_cnt_r != 16'hFFFF)) begin
      wait_cnt_r <= wait_cnt_r + 16'h1;
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // Key/plaintext registers, written on the cycle the 16th byte arrives.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      KIN_AES <= 128'h0;
      DIN_AES <= 128'h0;
    end else begin
      if (key_load_s) begin
        KIN_AES <= {rx_data_s[119:0], RX_DATA};
      end else begin
        KIN_AES <= KIN_AES;
      end
      if (dat_load_s) begin
        DIN_AES <= {rx_data_s[119:0], RX_DATA};
      end else begin
        DIN_AES <= DIN_AES;
      end
    end
  end

  // Registered handshake outputs, derived from the state being entered.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      KDRDY_AES <= 1'b0;
      EN_AES    <= 1'b0;
      RSTn_AES  <= 1'b0;
      TX_VLD    <= 1'b0;
    end else begin
      KDRDY_AES <= (state_nxt_s == ST_KEY_GO);
      EN_AES    <= en_s;
      RSTn_AES  <= (state_nxt_s != ST_RST_HOLD);
      TX_VLD    <= (state_nxt_s == ST_TX_RES) || (state_nxt_s == ST_TX_ACK);
    end
  end

  // Sticky overrun flag; only NRST clears it.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      OVR <= 1'b0;
    end else if (RX_VLD && !accepts_rx(state_r)) begin
      OVR <= 1'b1;
    end else begin
      OVR <= OVR;
    end
  end

endmodule
